// File: rtl/skein_scan_pkg.sv
// Shared types and widths for the skein nonce scanner.
// Imported by the scanner top and its result FIFO.
package skein_scan_pkg;

  localparam int HASH_W   = 512;
  localparam int DATA_W   = 96;
  localparam int NONCE_W  = 32;
  localparam int TARGET_W = 64;

  localparam int CMP_HI = HASH_W - 1;
  localparam int CMP_LO = HASH_W - TARGET_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic is_hit(
    input logic [HASH_W-1:0]   h,
    input logic [TARGET_W-1:0] t
  );
    return h[CMP_HI:CMP_LO] <= t;
  endfunction

endpackage

// File: rtl/skein_result_fifo.sv
// Winning-nonce FIFO with valid/ready read side.
// A push while full is taken only if a pop happens in the same cycle.
module skein_result_fifo
  import skein_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [NONCE_W-1:0] din,
  output logic               full,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NONCE_W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [NONCE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wp;
  logic [AW-1:0]      rp;
  logic [AW:0]        cnt;
  logic               pop;
  logic               wr;

  assign out_valid = cnt != '0;
  assign full      = cnt == (AW+1)'(DEPTH);
  assign pop       = out_valid & out_ready;
  assign wr        = push & (~full | pop);
  assign dout      = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/skein_nonce_scanner.sv
// Feeds one nonce per clock to the skein512 core and
// checks each returned hash against the work target.
module skein_nonce_scanner
  import skein_scan_pkg::*;
#(
  parameter int PIPE_LAT   = 80,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                work_valid,
  output logic                work_ready,
  input  logic [HASH_W-1:0]   work_midstate,
  input  logic [DATA_W-1:0]   work_data,
  input  logic [TARGET_W-1:0] work_target,
  input  logic [NONCE_W-1:0]  work_nonce_start,
  input  logic [NONCE_W-1:0]  work_nonce_end,
  input  logic                abort,
  output logic [HASH_W-1:0]   core_midstate,
  output logic [DATA_W-1:0]   core_data,
  output logic [NONCE_W-1:0]  core_nonce,
  input  logic [HASH_W-1:0]   core_hash,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  state_e              state;
  logic [PIPE_LAT-1:0] dl;
  logic [PIPE_LAT-1:0] dl_sh;
  logic [TARGET_W-1:0] target;
  logic [NONCE_W-1:0]  nonce_end;
  logic [NONCE_W-1:0]  chk_nonce;
  logic                accept;
  logic                chk_valid;
  logic                hit;
  logic                pop;
  logic                fifo_full;
  logic                drain_last;

  assign work_ready = state == ST_IDLE;
  assign busy       = state != ST_IDLE;
  assign accept     = work_valid & work_ready;
  assign dl_sh      = dl << 1;
  // only the output bit is left, so the line is empty after this shift
  assign drain_last = dl_sh == '0;
  assign chk_valid  = dl[PIPE_LAT-1];
  assign hit        = chk_valid & ~abort & is_hit(core_hash, target);
  assign pop        = res_valid & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      dl            <= '0;
      core_midstate <= '0;
      core_data     <= '0;
      core_nonce    <= '0;
      target        <= '0;
      nonce_end     <= '0;
      chk_nonce     <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (chk_valid)
        chk_nonce <= chk_nonce + 1'b1;
      if (hit & fifo_full & ~pop)
        overflow <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            core_midstate <= work_midstate;
            core_data     <= work_data;
            core_nonce    <= work_nonce_start;
            chk_nonce     <= work_nonce_start;
            target        <= work_target;
            nonce_end     <= work_nonce_end;
            overflow      <= 1'b0;
            state         <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (abort) begin
            dl    <= '0;
            state <= ST_IDLE;
          end else begin
            dl    <= dl_sh;
            dl[0] <= 1'b1;
            if (core_nonce == nonce_end)
              state <= ST_DRAIN;
            else
              core_nonce <= core_nonce + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            dl    <= '0;
            state <= ST_IDLE;
          end else begin
            dl <= dl_sh;
            if (drain_last) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  skein_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (hit),
    .din      (chk_nonce),
    .full     (fifo_full),
    .out_valid(res_valid),
    .out_ready(res_ready),
    .dout     (res_nonce)
  );

endmodule

// File: tb/tb_skein_nonce_scanner.sv
// Self-checking bench for skein_nonce_scanner with a
// delay-line core model whose hash top word is {0, nonce}.
module tb_skein_nonce_scanner;

  localparam int PL = 8;
  localparam int FD = 4;

  logic         clk;
  logic         rst;
  logic         work_valid;
  logic         work_ready;
  logic [511:0] work_midstate;
  logic [95:0]  work_data;
  logic [63:0]  work_target;
  logic [31:0]  work_nonce_start;
  logic [31:0]  work_nonce_end;
  logic         abort;
  logic [511:0] core_midstate;
  logic [95:0]  core_data;
  logic [31:0]  core_nonce;
  logic [511:0] core_hash;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic         busy;
  logic         done;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  skein_nonce_scanner #(
    .PIPE_LAT  (PL),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .work_valid      (work_valid),
    .work_ready      (work_ready),
    .work_midstate   (work_midstate),
    .work_data       (work_data),
    .work_target     (work_target),
    .work_nonce_start(work_nonce_start),
    .work_nonce_end  (work_nonce_end),
    .abort           (abort),
    .core_midstate   (core_midstate),
    .core_data       (core_data),
    .core_nonce      (core_nonce),
    .core_hash       (core_hash),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_nonce       (res_nonce),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural core: fixed PL-cycle latency
  logic [31:0] pipe [PL];
  always @(posedge clk) begin
    pipe[0] <= core_nonce;
    for (int i = 1; i < PL; i++)
      pipe[i] <= pipe[i-1];
  end
  assign core_hash = {32'h0, pipe[PL-1], {14{32'h5A3C_96E1}}};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0]  got [$];
  logic [31:0]  exp_q [$];
  logic [511:0] cur_mid;
  logic [95:0]  cur_data;
  logic         acc_ready, n1_busy, n1_ovf, n1_cap;
  logic [31:0]  n1_nonce;
  logic         done_wr, ab_busy, ab_wr;
  int           done_n, done_cnt, hold_bad;

  // expected hits: every nonce from s to e (inclusive, wrapping) <= target
  function automatic void build_exp(input logic [31:0] s, e, tg);
    logic [31:0] n;
    n = s;
    exp_q.delete();
    for (int k = 0; k < 100000; k++) begin
      if ({32'h0, n} <= {32'h0, tg})
        exp_q.push_back(n);
      if (n == e)
        break;
      n = n + 32'd1;
    end
  endfunction

  function automatic int list_bad();
    int b;
    b = 0;
    if (got.size() != exp_q.size())
      return 1;
    foreach (got[i])
      if (got[i] !== exp_q[i])
        b++;
    return b;
  endfunction

  task automatic run_scan(
    input logic [31:0] s, e, tg,
    input logic rdy,
    input int ab,
    input int len
  );
    logic [31:0] prev;
    logic        have_prev;
    got.delete();
    done_n    = -1;
    done_cnt  = 0;
    hold_bad  = 0;
    have_prev = 1'b0;
    done_wr   = 1'b0;
    ab_busy   = 1'b1;
    ab_wr     = 1'b0;
    for (int i = 0; i < 16; i++)
      cur_mid[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++)
      cur_data[i*32 +: 32] = $urandom;
    work_midstate    = cur_mid;
    work_data        = cur_data;
    work_target      = {32'h0, tg};
    work_nonce_start = s;
    work_nonce_end   = e;
    res_ready        = rdy;
    work_valid       = 1'b1;
    @(negedge clk);
    acc_ready = work_ready;
    @(posedge clk);
    #1;
    work_valid = 1'b0;
    for (int n = 1; n <= len; n++) begin
      abort = (n == ab);
      @(negedge clk);
      if (n == 1) begin
        n1_busy  = busy;
        n1_nonce = core_nonce;
        n1_ovf   = overflow;
        n1_cap   = (core_midstate === cur_mid) && (core_data === cur_data);
      end
      if (res_valid && res_ready)
        got.push_back(res_nonce);
      if (res_valid && !res_ready) begin
        if (have_prev && prev !== res_nonce)
          hold_bad++;
        prev      = res_nonce;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_n < 0) begin
          done_n  = n;
          done_wr = work_ready;
        end
      end
      if (n == ab + 1) begin
        ab_busy = busy;
        ab_wr   = work_ready;
      end
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (work_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_work_ready got %b want 1", work_ready);
    end
    checks++;
    if ({busy, done, overflow, res_valid} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 0000",
               {busy, done, overflow, res_valid});
    end
    checks++;
    if (core_nonce !== 32'h0 || res_nonce !== 32'h0) begin
      errors++;
      $display("FAIL rst_nonces got %h/%h want 0/0", core_nonce, res_nonce);
    end
    checks++;
    if (core_midstate !== '0 || core_data !== '0) begin
      errors++;
      $display("FAIL rst_core_bus got nonzero want 0");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (work_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release got ready=%b busy=%b want 1/0",
               work_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    build_exp(32'h10, 32'h1F, 32'h14);
    run_scan(32'h10, 32'h1F, 32'h14, 1'b1, 0, 16 + PL + 6);
    checks++;
    if (acc_ready !== 1'b1 || n1_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept got ready=%b busy=%b want 1/1",
               acc_ready, n1_busy);
    end
    checks++;
    if (n1_nonce !== 32'h10) begin
      errors++;
      $display("FAIL basic_first_nonce got %h want 00000010", n1_nonce);
    end
    checks++;
    if (n1_cap !== 1'b1) begin
      errors++;
      $display("FAIL basic_capture got %b want 1", n1_cap);
    end
    checks++;
    if (list_bad() != 0) begin
      errors++;
      $display("FAIL basic_results got %0d items want %0d",
               got.size(), exp_q.size());
    end
    checks++;
    if (done_n != 25 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done got at %0d x%0d want at 25 x1",
               done_n, done_cnt);
    end
    checks++;
    if (done_wr !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got wr=%b busy=%b ovf=%b want 1/0/0",
               done_wr, busy, overflow);
    end
  endtask

  task automatic test_wrap();
    exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    run_scan(32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 1'b1, 0, 4 + PL + 6);
    checks++;
    if (list_bad() != 0) begin
      errors++;
      $display("FAIL wrap_results got %0d items want 4", got.size());
    end
    checks++;
    if (done_n != 4 + PL + 1) begin
      errors++;
      $display("FAIL wrap_done got %0d want %0d", done_n, 4 + PL + 1);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    s = $urandom;
    run_scan(s, s + 32'd5, 32'hFFFF_FFFF, 1'b0, 0, 6 + PL + 6);
    checks++;
    if (overflow !== 1'b1 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flags got ovf=%b valid=%b want 1/1",
               overflow, res_valid);
    end
    checks++;
    if (res_nonce !== s || hold_bad != 0) begin
      errors++;
      $display("FAIL ovf_head got %h unstable=%0d want %h stable",
               res_nonce, hold_bad, s);
    end
    checks++;
    if (done_n != 6 + PL + 1) begin
      errors++;
      $display("FAIL ovf_done got %0d want %0d", done_n, 6 + PL + 1);
    end
    got.delete();
    exp_q = '{s, s + 32'd1, s + 32'd2, s + 32'd3};
    res_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (res_valid && res_ready)
        got.push_back(res_nonce);
      @(posedge clk);
      #1;
    end
    checks++;
    if (list_bad() != 0) begin
      errors++;
      $display("FAIL ovf_held got %0d items want 4", got.size());
    end
    checks++;
    if (res_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got valid=%b ovf=%b want 0/1",
               res_valid, overflow);
    end
    run_scan(32'd5, 32'd5, 32'd0, 1'b1, 0, 1 + PL + 6);
    checks++;
    if (n1_ovf !== 1'b0 || got.size() != 0) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%b items=%0d want 0/0",
               n1_ovf, got.size());
    end
  endtask

  task automatic test_abort();
    logic [31:0] s;
    s = $urandom;
    run_scan(s, s + 32'd99, 32'hFFFF_FFFF, 1'b1, 3, 40);
    checks++;
    if (ab_busy !== 1'b0 || ab_wr !== 1'b1) begin
      errors++;
      $display("FAIL abort_scan got busy=%b ready=%b want 0/1",
               ab_busy, ab_wr);
    end
    checks++;
    if (done_cnt != 0 || got.size() != 0) begin
      errors++;
      $display("FAIL abort_scan_quiet got done=%0d items=%0d want 0/0",
               done_cnt, got.size());
    end
    s = $urandom;
    exp_q = '{s, s + 32'd1, s + 32'd2};
    run_scan(s, s + 32'd19, 32'hFFFF_FFFF, 1'b1, PL + 4, 40);
    checks++;
    if (list_bad() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_hit_cycle got items=%0d done=%0d want 3/0",
               got.size(), done_cnt);
    end
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || work_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle got busy=%b ready=%b want 0/1",
               busy, work_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_drain();
    logic [31:0] s;
    s = $urandom;
    work_target      = 64'hFFFF_FFFF;
    work_nonce_start = s;
    work_nonce_end   = s + 32'd3;
    res_ready        = 1'b0;
    work_valid       = 1'b1;
    @(posedge clk);
    #1;
    work_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_pre got busy=%b valid=%b want 1/1",
               busy, res_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, overflow, res_valid, work_ready} !== 5'b00001 ||
        core_nonce !== 32'h0 || res_nonce !== 32'h0 ||
        core_midstate !== '0 || core_data !== '0) begin
      errors++;
      $display("FAIL drain_rst got flags=%b nonce=%h want 00001 0",
               {busy, done, overflow, res_valid, work_ready}, core_nonce);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    build_exp(32'h200, 32'h20B, 32'h204);
    run_scan(32'h200, 32'h20B, 32'h204, 1'b1, 0, 12 + PL + 6);
    checks++;
    if (list_bad() != 0 || done_n != 12 + PL + 1) begin
      errors++;
      $display("FAIL drain_after got items=%0d done=%0d want %0d/%0d",
               got.size(), done_n, exp_q.size(), 12 + PL + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] s, e, tg;
    int k;
    for (int it = 0; it < 6; it++) begin
      k  = $urandom_range(1, 30);
      s  = (it % 2 == 0) ? $urandom : 32'hFFFF_FFFF - $urandom_range(0, 20);
      e  = s + 32'(k - 1);
      tg = s + 32'($urandom_range(0, k));
      build_exp(s, e, tg);
      run_scan(s, e, tg, 1'b1, 0, k + PL + 6);
      checks++;
      if (list_bad() != 0) begin
        errors++;
        $display("FAIL rand_results it=%0d got %0d items want %0d",
                 it, got.size(), exp_q.size());
      end
      checks++;
      if (done_n != k + PL + 1 || done_cnt != 1) begin
        errors++;
        $display("FAIL rand_done it=%0d got %0d want %0d",
                 it, done_n, k + PL + 1);
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    work_valid       = 1'b0;
    work_midstate    = '0;
    work_data        = '0;
    work_target      = '0;
    work_nonce_start = '0;
    work_nonce_end   = '0;
    abort            = 1'b0;
    res_ready        = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_abort();
    test_reset_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
